meteor_scheduler: RTL and testbench

//  Sequences the falling-meteor datapath for Meteor Dodge: owns NUM_METEORS slots (x, y, active),

---
 rtl/meteor_pkg.sv | 24 ++
 rtl/meteor_lfsr.sv | 26 ++
 rtl/meteor_scheduler.sv | 176 +++++++++++++++++
 tb/tb_meteor_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/meteor_pkg.sv
// Shared definitions for the Meteor Dodge meteor scheduler: run-state
// encodings, coordinate and score widths, and the LFSR seed/taps.
package meteor_pkg;

    localparam int COORD_W = 10;
    localparam int SCORE_W = 16;
    localparam int LFSR_W  = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as a mask over bits [15],[13],[12],[10]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } run_state_t;

    // One Fibonacci step: shift left, feed the XOR of the tapped bits into bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/meteor_lfsr.sv
// 16-bit Fibonacci LFSR that free-runs every clock from the seed; exposes
// only the low OUT_W bits that the spawn logic consumes.
module meteor_lfsr
    import meteor_pkg::*;
#(
    parameter int OUT_W = 9
) (
    input  logic             clock,
    input  logic             reset,
    output logic [OUT_W-1:0] value
);

    logic [LFSR_W-1:0] state_q;

    // Step the shift register every cycle; the nonzero seed keeps it off the all-zero lockup state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign value = state_q[OUT_W-1:0];

endmodule

// File: rtl/meteor_scheduler.sv
// Meteor Dodge meteor scheduler: owns the meteor slots, spawns at LFSR
// columns, moves meteors each frame, retires them at the bottom and keeps
// score. Optional macro SPEEDUP_EN makes fall speed grow with the score.
module meteor_scheduler
    import meteor_pkg::*;
#(
    parameter int NUM_METEORS  = 4,
    parameter int SPAWN_PERIOD = 45,
    parameter int Y_LIMIT      = 480,
    parameter int X_MIN        = 64,
    parameter int BASE_SPEED   = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           frame_tick,
    input  logic                           collide,
    output logic [NUM_METEORS-1:0]         met_active,
    output logic [NUM_METEORS*COORD_W-1:0] met_x,
    output logic [NUM_METEORS*COORD_W-1:0] met_y,
    output logic [SCORE_W-1:0]             score,
    output logic [1:0]                     run_state,
    output logic                           game_over
);

    localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int IDX_W = (NUM_METEORS > 1) ? $clog2(NUM_METEORS) : 1;
    localparam int RET_W = $clog2(NUM_METEORS + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);
    localparam logic [COORD_W:0]   Y_LIM    = (COORD_W + 1)'(Y_LIMIT);
    localparam logic [COORD_W-1:0] X_BASE   = COORD_W'(X_MIN);

    run_state_t         state_q, state_d;
    logic               game_over_q;
    logic [CNT_W-1:0]   spawn_cnt_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W:0]   score_sum;
    logic [RET_W-1:0]   ret_count;
    logic [NUM_METEORS-1:0] retire;
    logic [8:0]         lfsr_low;
    logic [4:0]         speed;
    logic               do_tick, do_clear, spawn_now, free_found;
    logic [IDX_W-1:0]   free_idx;

    meteor_lfsr #(.OUT_W(9)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .value (lfsr_low)
    );

`ifdef SPEEDUP_EN
    logic [2:0] bonus;
    assign bonus = (score_q[5:3] > 3'd4) ? 3'd4 : score_q[5:3];
    assign speed = 5'(BASE_SPEED) + 5'(bonus);
`else
    assign speed = 5'(BASE_SPEED);
`endif

    // A collision in the same cycle as a frame tick suppresses the whole frame update
    assign do_tick   = (state_q == ST_RUN) && frame_tick && !collide;
    assign do_clear  = (state_q == ST_OVER) && start;
    assign spawn_now = do_tick && (spawn_cnt_q == CNT_LAST) && free_found;

    // Run-state next-state logic: start arms play, collide ends it, start from OVER returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)   state_d = ST_RUN;
            ST_RUN:  if (collide) state_d = ST_OVER;
            ST_OVER: if (start)   state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // Run-state register plus a registered game_over flag that tracks the OVER state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            game_over_q <= (state_d == ST_OVER);
        end
    end

    // Lowest-index free slot, judged on occupancy before this tick's retirements
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_METEORS - 1; i >= 0; i--) begin
            if (!met_active[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Spawn counter advances per RUN frame and wraps at the period whether or not a slot was free
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spawn_cnt_q <= '0;
        end else if (do_clear) begin
            spawn_cnt_q <= '0;
        end else if (do_tick) begin
            if (spawn_cnt_q == CNT_LAST) begin
                spawn_cnt_q <= '0;
            end else begin
                spawn_cnt_q <= spawn_cnt_q + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_METEORS; i++) begin : g_slot
        logic               act_q;
        logic [COORD_W-1:0] x_q, y_q;
        logic [COORD_W:0]   sum;

        assign sum       = {1'b0, y_q} + (COORD_W + 1)'(speed);
        assign retire[i] = do_tick && act_q && (sum >= Y_LIM);

        // Per-slot state: move or retire a live meteor, or load a fresh one when picked for a spawn
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                act_q <= 1'b0;
                x_q   <= '0;
                y_q   <= '0;
            end else if (do_clear) begin
                act_q <= 1'b0;
                x_q   <= '0;
                y_q   <= '0;
            end else if (do_tick) begin
                if (act_q) begin
                    if (sum >= Y_LIM) begin
                        act_q <= 1'b0;
                    end else begin
                        y_q <= sum[COORD_W-1:0];
                    end
                end else if (spawn_now && (free_idx == IDX_W'(i))) begin
                    act_q <= 1'b1;
                    x_q   <= X_BASE + COORD_W'(lfsr_low);
                    y_q   <= '0;
                end
            end
        end

        assign met_active[i]                = act_q;
        assign met_x[COORD_W*i +: COORD_W]  = x_q;
        assign met_y[COORD_W*i +: COORD_W]  = y_q;
    end

    // Number of meteors leaving the bottom on this tick
    always_comb begin
        ret_count = '0;
        for (int i = 0; i < NUM_METEORS; i++) begin
            ret_count = ret_count + RET_W'(retire[i]);
        end
    end

    assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(ret_count);

    // Score accumulates retirements and saturates rather than wrapping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            score_q <= '0;
        end else if (do_clear) begin
            score_q <= '0;
        end else if (do_tick) begin
            score_q <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end
    end

    assign score     = score_q;
    assign run_state = state_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_meteor_scheduler.sv
// Directed bench for meteor_scheduler. Instance u_dut uses default
// parameters; u_dut_b uses SPAWN_PERIOD=240 so that a retirement and a
// spawn fall on the same frame tick.
module tb_meteor_scheduler;

    logic        clock;
    logic        reset;
    logic        start, frame_tick, collide;
    logic [3:0]  met_active;
    logic [39:0] met_x, met_y;
    logic [15:0] score;
    logic [1:0]  run_state;
    logic        game_over;

    logic        start_b, frame_tick_b, collide_b;
    logic [3:0]  met_active_b;
    logic [39:0] met_x_b, met_y_b;
    logic [15:0] score_b;
    logic [1:0]  run_state_b;
    logic        game_over_b;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] m_lfsr;
    logic [9:0]  tick_x;
    logic [9:0]  x0, x1, x2, x3, bx0, bx1;

    meteor_scheduler u_dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .frame_tick (frame_tick),
        .collide    (collide),
        .met_active (met_active),
        .met_x      (met_x),
        .met_y      (met_y),
        .score      (score),
        .run_state  (run_state),
        .game_over  (game_over)
    );

    meteor_scheduler #(.SPAWN_PERIOD(240)) u_dut_b (
        .clock      (clock),
        .reset      (reset),
        .start      (start_b),
        .frame_tick (frame_tick_b),
        .collide    (collide_b),
        .met_active (met_active_b),
        .met_x      (met_x_b),
        .met_y      (met_y_b),
        .score      (score_b),
        .run_state  (run_state_b),
        .game_over  (game_over_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference LFSR: seed ACE1, taps 16,14,13,11, steps every clock
    always @(posedge clock or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    // All tasks start and end on a falling edge
    task automatic tick_a();
        frame_tick = 1'b1;
        tick_x = 10'd64 + {1'b0, m_lfsr[8:0]};
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    task automatic run_a(input int n);
        repeat (n) tick_a();
    endtask

    task automatic tick_b();
        frame_tick_b = 1'b1;
        tick_x = 10'd64 + {1'b0, m_lfsr[8:0]};
        @(negedge clock);
        frame_tick_b = 1'b0;
    endtask

    task automatic run_b(input int n);
        repeat (n) tick_b();
    endtask

    task automatic pulse_start_a();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (met_active !== 4'b0) begin tests_failed++; $display("[TB] FAIL reset_active: got %b want 0000", met_active); end
        tests_run++;
        if (met_x !== 40'd0 || met_y !== 40'd0) begin tests_failed++; $display("[TB] FAIL reset_xy: got x=%h y=%h want 0", met_x, met_y); end
        tests_run++;
        if (score !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_score: got %0d want 0", score); end
        tests_run++;
        if (run_state !== 2'b00 || game_over !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_state: got %b/%b want 00/0", run_state, game_over); end
    endtask

    task automatic test_idle();
        run_a(3);
        tests_run++;
        if (met_active !== 4'b0 || run_state !== 2'b00) begin tests_failed++; $display("[TB] FAIL idle_ignore: got act=%b st=%b want 0000/00", met_active, run_state); end
    endtask

    task automatic test_spawn();
        pulse_start_a();
        tests_run++;
        if (run_state !== 2'b01) begin tests_failed++; $display("[TB] FAIL start_run: got %b want 01", run_state); end
        run_a(44);
        tests_run++;
        if (met_active !== 4'b0) begin tests_failed++; $display("[TB] FAIL early_spawn: got %b want 0000", met_active); end
        tick_a();
        x0 = tick_x;
        tests_run++;
        if (met_active !== 4'b0001) begin tests_failed++; $display("[TB] FAIL spawn_active: got %b want 0001", met_active); end
        tests_run++;
        if (met_x[9:0] !== x0 || met_y[9:0] !== 10'd0) begin tests_failed++; $display("[TB] FAIL spawn_xy: got x=%0d y=%0d want x=%0d y=0", met_x[9:0], met_y[9:0], x0); end
        run_a(10);
        tests_run++;
        if (met_y[9:0] !== 10'd20 || met_x[9:0] !== x0) begin tests_failed++; $display("[TB] FAIL move_y: got x=%0d y=%0d want x=%0d y=20", met_x[9:0], met_y[9:0], x0); end
        pulse_start_a();
        tests_run++;
        if (run_state !== 2'b01) begin tests_failed++; $display("[TB] FAIL start_in_run: got %b want 01", run_state); end
    endtask

    task automatic test_full_slots();
        run_a(34); tick_a(); x1 = tick_x;
        run_a(44); tick_a(); x2 = tick_x;
        run_a(44); tick_a(); x3 = tick_x;
        tests_run++;
        if (met_active !== 4'b1111 || met_x !== {x3, x2, x1, x0}) begin tests_failed++; $display("[TB] FAIL fill_slots: got act=%b x=%h want 1111 x=%h", met_active, met_x, {x3, x2, x1, x0}); end
        run_a(44); tick_a();
        tests_run++;
        if (met_active !== 4'b1111 || met_x !== {x3, x2, x1, x0}) begin tests_failed++; $display("[TB] FAIL full_skip: got act=%b x=%h want 1111 x=%h", met_active, met_x, {x3, x2, x1, x0}); end
        tests_run++;
        if (met_y !== {10'd90, 10'd180, 10'd270, 10'd360}) begin tests_failed++; $display("[TB] FAIL full_y: got %h want %h", met_y, {10'd90, 10'd180, 10'd270, 10'd360}); end
        run_a(59); tick_a();
        tests_run++;
        if (met_active !== 4'b1110 || score !== 16'd1) begin tests_failed++; $display("[TB] FAIL retire: got act=%b score=%0d want 1110/1", met_active, score); end
        tests_run++;
        if (met_y !== {10'd210, 10'd300, 10'd390, 10'd478}) begin tests_failed++; $display("[TB] FAIL retire_y: got %h want %h", met_y, {10'd210, 10'd300, 10'd390, 10'd478}); end
        run_a(29);
        tests_run++;
        if (met_active !== 4'b1110) begin tests_failed++; $display("[TB] FAIL wrap_wait: got %b want 1110", met_active); end
        tick_a(); x0 = tick_x;
        tests_run++;
        if (met_active !== 4'b1111 || met_x[9:0] !== x0) begin tests_failed++; $display("[TB] FAIL refill: got act=%b x0=%0d want 1111 x0=%0d", met_active, met_x[9:0], x0); end
        tests_run++;
        if (met_y !== {10'd270, 10'd360, 10'd450, 10'd0}) begin tests_failed++; $display("[TB] FAIL refill_y: got %h want %h", met_y, {10'd270, 10'd360, 10'd450, 10'd0}); end
    endtask

    task automatic test_collide();
        frame_tick = 1'b1;
        collide    = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        collide    = 1'b0;
        tests_run++;
        if (run_state !== 2'b10 || game_over !== 1'b1) begin tests_failed++; $display("[TB] FAIL collide_state: got %b/%b want 10/1", run_state, game_over); end
        tests_run++;
        if (met_y !== {10'd270, 10'd360, 10'd450, 10'd0} || score !== 16'd1) begin tests_failed++; $display("[TB] FAIL collide_freeze: got y=%h score=%0d want %h/1", met_y, score, {10'd270, 10'd360, 10'd450, 10'd0}); end
        collide = 1'b1;
        run_a(3);
        collide = 1'b0;
        tests_run++;
        if (met_y !== {10'd270, 10'd360, 10'd450, 10'd0} || met_active !== 4'b1111 || run_state !== 2'b10) begin tests_failed++; $display("[TB] FAIL over_frozen: got y=%h act=%b st=%b", met_y, met_active, run_state); end
        pulse_start_a();
        tests_run++;
        if (run_state !== 2'b00 || score !== 16'd0 || met_active !== 4'b0 || game_over !== 1'b0) begin tests_failed++; $display("[TB] FAIL over_to_idle: got st=%b score=%0d act=%b go=%b want 00/0/0000/0", run_state, score, met_active, game_over); end
        run_a(2);
        pulse_start_a();
        tests_run++;
        if (run_state !== 2'b01) begin tests_failed++; $display("[TB] FAIL restart: got %b want 01", run_state); end
        run_a(44);
        tests_run++;
        if (met_active !== 4'b0) begin tests_failed++; $display("[TB] FAIL counter_cleared: got %b want 0000", met_active); end
        tick_a(); x0 = tick_x;
        tests_run++;
        if (met_active !== 4'b0001 || met_x[9:0] !== x0) begin tests_failed++; $display("[TB] FAIL restart_spawn: got act=%b x=%0d want 0001 x=%0d", met_active, met_x[9:0], x0); end
    endtask

    task automatic test_reset_mid_run();
        run_a(45);
        tests_run++;
        if (met_active !== 4'b0011) begin tests_failed++; $display("[TB] FAIL two_live: got %b want 0011", met_active); end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (met_active !== 4'b0 || met_x !== 40'd0 || met_y !== 40'd0 || score !== 16'd0 || run_state !== 2'b00 || game_over !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: got act=%b x=%h y=%h score=%0d st=%b go=%b want all 0", met_active, met_x, met_y, score, run_state, game_over);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_retire_spawn_same_tick();
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        run_b(239);
        tick_b(); bx0 = tick_x;
        tests_run++;
        if (met_active_b !== 4'b0001 || met_x_b[9:0] !== bx0) begin tests_failed++; $display("[TB] FAIL b_spawn: got act=%b x=%0d want 0001 x=%0d", met_active_b, met_x_b[9:0], bx0); end
        run_b(239);
        tests_run++;
        if (met_y_b[9:0] !== 10'd478) begin tests_failed++; $display("[TB] FAIL b_y478: got %0d want 478", met_y_b[9:0]); end
        tick_b(); bx1 = tick_x;
        tests_run++;
        if (met_active_b !== 4'b0010 || score_b !== 16'd1) begin tests_failed++; $display("[TB] FAIL b_retire_pick: got act=%b score=%0d want 0010/1", met_active_b, score_b); end
        tests_run++;
        if (met_x_b[19:10] !== bx1 || met_y_b[19:10] !== 10'd0 || met_y_b[9:0] !== 10'd478) begin
            tests_failed++;
            $display("[TB] FAIL b_slot_xy: got x1=%0d y1=%0d y0=%0d want x1=%0d y1=0 y0=478", met_x_b[19:10], met_y_b[19:10], met_y_b[9:0], bx1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        frame_tick   = 1'b0;
        collide      = 1'b0;
        start_b      = 1'b0;
        frame_tick_b = 1'b0;
        collide_b    = 1'b0;
        @(negedge clock);
        @(negedge clock);
        test_reset();
        reset = 1'b0;
        @(negedge clock);
        test_idle();
        test_spawn();
        test_full_slots();
        test_collide();
        test_reset_mid_run();
        test_retire_spawn_same_tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
